axi_complex_gain_mc: RTL
========================

Name: axi_complex_gain_mc

Overview:
- Multi-channel complex gain stage for RFNoC compute engines; sits between the axi_wrapper m_axis/s_axis data ports.
- Supports per-channel gain selected by i_tuser, parametrised I/Q, gain and output widths, and convergent-free round-half-up with saturation.
- Adds optional linear gain ramping, to avoid step transients, and a saturating clip counter exposed on a readback port.

Parameters:
- WIDTH_IN, 16, signed width of each I and Q input component.
- WIDTH_GAIN, 16, signed gain width; must be ≤16.
- GAIN_FRAC, 14, fractional bits of gain; 1<<GAIN_FRAC represents unity.
- WIDTH_OUT, 16, signed width of each I and Q output component.
- NUM_CHAN, 4, number of channels, 1..256; channel index width CW=max(1,clog2(NUM_CHAN)).
- RAMP_LOG2, 4, a ramp spans 2^RAMP_LOG2 samples of that channel; range 1..8.
- SR_BASE, 192, settings address base; uses SR_BASE and SR_BASE+1.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  2*WIDTH_IN  sample: {I,Q}, I in upper half.
- i_tuser  in  CW  channel index of the sample.
- i_tlast, i_tvalid  in  1  AXI-S input.
- i_tready  out  1  AXI-S input ready.
- o_tdata  out  2*WIDTH_OUT  {I,Q} result.
- o_tuser  out  CW  channel index, delayed with the data.
- o_tlast, o_tvalid  out  1  AXI-S output.
- o_tready  in  1  AXI-S output ready.
- rb_sel  in  CW+1  readback select; MSB=1 selects the clip counter, otherwise the channel in the low bits.
- rb_data  out  64  registered readback.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - all pipeline valids 0, so o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0;
  - every channel's current and target gain = 1<<GAIN_FRAC, ramp counters 0, ramp_en=0, clip counter 0, rb_data 0.
  - Reset mid-stream drops all in-flight samples; no partial output.
- Pipeline: 3 stages (capture/gain-select, multiply, round/saturate). Latency is 3 clk from input handshake to o_tvalid when unstalled.
- Handshake:
  - global enable en = o_tready | ~o_tvalid; i_tready = en.
  - All stages advance together when en=1.
  - Bubbles are not collapsed.
  - o_tdata, o_tuser and o_tlast are held stable while o_tvalid=1 and o_tready=0.
- Arithmetic, per component:
  - p = x*g, signed, WIDTH_IN+WIDTH_GAIN bits.
  - r = (p + (1<<(GAIN_FRAC-1))) >>> GAIN_FRAC, i.e. round half toward +inf.
  - Saturate r to [-(2^(WIDTH_OUT-1)), 2^(WIDTH_OUT-1)-1].
- Clip counter: increments once per output sample in which I or Q saturated. Counter is 32-bit, saturates at 0xFFFFFFFF, and counts only on output handshake.
- Gain used for a sample is that channel's current gain at input-handshake time.
- SR_BASE write:
  - set_data[31:24] = channel, set_data[WIDTH_GAIN-1:0] = target gain.
  - Channel ≥ NUM_CHAN: write ignored.
  - ramp_en=0: current := target immediately; it takes effect on the next accepted sample of that channel.
  - ramp_en=1: target := new value; step := (target − current) >>> RAMP_LOG2, computed with WIDTH_GAIN+1 bits; counter := 2^RAMP_LOG2.
- SR_BASE+1 write:
  - bit0 = ramp_en.
  - bit1 = clear clip counter; self-clearing, and takes effect the next cycle.
- Ramp stepping: on each accepted sample of a channel with counter>0:
  - counter decrements;
  - if the new counter ≠ 0, current += step; if the new counter = 0, current := target exactly.
  - Step=0 (small delta) still snaps to target at the end.
- Simultaneous settings write and accepted sample on the same channel:
  - the sample uses the pre-write current gain;
  - the write wins, so no ramp step is applied that cycle;
  - the ramp restarts from that pre-step current value.
- A new gain write during an active ramp restarts the ramp from the present current value.
- Readback: rb_data is registered one cycle after rb_sel.
  - Channel select: {16'b0, sign-extended target[15:0], sign-extended current[15:0], 7'b0, counter[8:0]}.
  - Clip-counter select: {32'b0, clip_count}.

Test Plan:
- Defaults, gain 0x4000 (unity), input I=1000 Q=-1000 on ch0 → output I=1000 Q=-1000 exactly 3 cycles after handshake; o_tuser=0, tlast preserved.
- Gain ch1=0x7FFF, input I=0x7FFF Q=0x8000 → output I=0x7FFF Q=0x8000 (both saturated); clip counter readback = 1; SR_BASE+1 bit1 → counter reads 0.
- ramp_en=1, RAMP_LOG2=2, ch0 current 0x4000, write target 0 → five I=1000 samples on ch0 give 1000, 750, 500, 250, 0; ch2 samples interleaved stay at unity.
- Random o_tready (50%) over 1000 samples on 4 channels vs. reference model → no loss or duplication, output held while stalled, per-channel gain correct.
- Rounding: gain 0x2000 (0.5), I=3 → 2; I=-3 → -1.
- reset_n low for 1 cycle with 3 samples in flight → o_tvalid=0 the next cycle; gains back to 0x4000; no stale samples afterward.

Source files
------------

// File: rtl/axi_complex_gain_mc.sv
// Multi-channel complex gain: per-channel gain (optionally ramped), round-half-up, saturation, clip count.
// Latency 3 clk; every stage advances only when o_tready | ~o_tvalid, and that same term drives i_tready.
module axi_complex_gain_mc #(
   parameter int WIDTH_IN   = 16,
   parameter int WIDTH_GAIN = 16,
   parameter int GAIN_FRAC  = 14,
   parameter int WIDTH_OUT  = 16,
   parameter int NUM_CHAN   = 4,
   parameter int RAMP_LOG2  = 4,
   parameter int SR_BASE    = 192,
   localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   set_stb,
   input  logic [7:0]             set_addr,
   input  logic [31:0]            set_data,
   input  logic [2*WIDTH_IN-1:0]  i_tdata,
   input  logic [CW-1:0]          i_tuser,
   input  logic                   i_tlast,
   input  logic                   i_tvalid,
   output logic                   i_tready,
   output logic [2*WIDTH_OUT-1:0] o_tdata,
   output logic [CW-1:0]          o_tuser,
   output logic                   o_tlast,
   output logic                   o_tvalid,
   input  logic                   o_tready,
   input  logic [CW:0]            rb_sel,
   output logic [63:0]            rb_data
);
   localparam int PW = WIDTH_IN + WIDTH_GAIN;
   localparam int RW = RAMP_LOG2 + 1;
   localparam logic signed [PW:0] OMAX = (PW+1)'((longint'(1) << (WIDTH_OUT-1)) - 1);
   localparam logic signed [PW:0] OMIN = -OMAX - (PW+1)'(1);
   localparam logic signed [PW:0] HALF = (PW+1)'(longint'(1) << (GAIN_FRAC-1));
   localparam logic signed [WIDTH_GAIN-1:0] UNITY = WIDTH_GAIN'(longint'(1) << GAIN_FRAC);

   logic en, in_acc, out_acc, wr_gain, wr_ctl;
   logic signed [WIDTH_GAIN-1:0] wr_val, gsel;
   logic unused_set;

   logic signed [WIDTH_GAIN-1:0] cur_q [NUM_CHAN], cur_d [NUM_CHAN];
   logic signed [WIDTH_GAIN-1:0] tgt_q [NUM_CHAN], tgt_d [NUM_CHAN];
   logic signed [WIDTH_GAIN:0]   step_q [NUM_CHAN], step_d [NUM_CHAN];
   logic [RW-1:0]                cnt_q [NUM_CHAN], cnt_d [NUM_CHAN];
   logic        ramp_en_q, ramp_en_d, clr_q, clr_d;
   logic [31:0] clip_q, clip_d;
   logic [63:0] rb_q, rb_d;

   logic                         v1_q, v1_d, l1_q, l1_d, v2_q, v2_d, l2_q, l2_d, v3_q, v3_d, l3_q, l3_d;
   logic                         sat3_q, sat3_d;
   logic [CW-1:0]                u1_q, u1_d, u2_q, u2_d, u3_q, u3_d;
   logic [2*WIDTH_IN-1:0]        d1_q, d1_d;
   logic signed [WIDTH_GAIN-1:0] g1_q, g1_d;
   logic signed [PW-1:0]         pi2_q, pi2_d, pq2_q, pq2_d;
   logic [2*WIDTH_OUT-1:0]       o3_q, o3_d;
   logic [WIDTH_OUT:0]           ri, rq;

   assign en         = o_tready | ~v3_q;
   assign i_tready   = en;
   assign in_acc     = i_tvalid & en;
   assign out_acc    = v3_q & o_tready;
   assign wr_gain    = set_stb && (set_addr == 8'(SR_BASE));
   assign wr_ctl     = set_stb && (set_addr == 8'(SR_BASE + 1));
   assign wr_val     = set_data[WIDTH_GAIN-1:0];
   assign unused_set = ^set_data[23:WIDTH_GAIN];

   // Returns {saturated, value}; the sum is one bit wider so the rounding offset cannot wrap.
   function automatic logic [WIDTH_OUT:0] rnd_sat(input logic signed [PW-1:0] p);
      logic signed [PW:0] r;
      r = ($signed({p[PW-1], p}) + HALF) >>> GAIN_FRAC;
      if (r > OMAX)      rnd_sat = {1'b1, OMAX[WIDTH_OUT-1:0]};
      else if (r < OMIN) rnd_sat = {1'b1, OMIN[WIDTH_OUT-1:0]};
      else               rnd_sat = {1'b0, r[WIDTH_OUT-1:0]};
   endfunction

   always_comb begin
      gsel = cur_q[0];
      for (int c = 0; c < NUM_CHAN; c++)
         if (i_tuser == CW'(c)) gsel = cur_q[c];
   end

   always_comb begin
      ramp_en_d = wr_ctl ? set_data[0] : ramp_en_q;
      clr_d     = wr_ctl & set_data[1];
      clip_d    = clip_q;
      if (clr_q)
         clip_d = '0;
      else if (out_acc && sat3_q && clip_q != '1)
         clip_d = clip_q + 32'd1;
      for (int c = 0; c < NUM_CHAN; c++) begin
         cur_d[c]  = cur_q[c];
         tgt_d[c]  = tgt_q[c];
         step_d[c] = step_q[c];
         cnt_d[c]  = cnt_q[c];
         if (in_acc && i_tuser == CW'(c) && cnt_q[c] != '0) begin
            cnt_d[c] = cnt_q[c] - RW'(1);
            cur_d[c] = (cnt_q[c] == RW'(1)) ? tgt_q[c] : cur_q[c] + step_q[c][WIDTH_GAIN-1:0];
         end
         // A write to the same channel overrides any ramp step taken this cycle.
         if (wr_gain && set_data[31:24] == 8'(c)) begin
            tgt_d[c] = wr_val;
            if (ramp_en_q) begin
               cur_d[c]  = cur_q[c];
               step_d[c] = $signed({wr_val[WIDTH_GAIN-1], wr_val} - {cur_q[c][WIDTH_GAIN-1], cur_q[c]}) >>> RAMP_LOG2;
               cnt_d[c]  = RW'(1) << RAMP_LOG2;
            end else begin
               cur_d[c] = wr_val;
               cnt_d[c] = '0;
            end
         end
      end
   end

   always_comb begin
      rb_d = '0;
      if (rb_sel[CW])
         rb_d = {32'b0, clip_q};
      else
         for (int c = 0; c < NUM_CHAN; c++)
            if (rb_sel[CW-1:0] == CW'(c))
               rb_d = {16'b0, 16'(tgt_q[c]), 16'(cur_q[c]), 7'b0, 9'(cnt_q[c])};
   end

   always_comb begin
      v1_d = v1_q;   d1_d = d1_q;   u1_d = u1_q;   l1_d = l1_q;   g1_d = g1_q;
      v2_d = v2_q;   pi2_d = pi2_q; pq2_d = pq2_q; u2_d = u2_q;   l2_d = l2_q;
      v3_d = v3_q;   o3_d = o3_q;   u3_d = u3_q;   l3_d = l3_q;   sat3_d = sat3_q;
      ri   = rnd_sat(pi2_q);
      rq   = rnd_sat(pq2_q);
      if (en) begin
         v1_d   = i_tvalid;
         d1_d   = i_tdata;
         u1_d   = i_tuser;
         l1_d   = i_tlast;
         g1_d   = gsel;
         v2_d   = v1_q;
         pi2_d  = PW'($signed(d1_q[2*WIDTH_IN-1:WIDTH_IN])) * PW'(g1_q);
         pq2_d  = PW'($signed(d1_q[WIDTH_IN-1:0])) * PW'(g1_q);
         u2_d   = u1_q;
         l2_d   = l1_q;
         v3_d   = v2_q;
         o3_d   = {ri[WIDTH_OUT-1:0], rq[WIDTH_OUT-1:0]};
         sat3_d = ri[WIDTH_OUT] | rq[WIDTH_OUT];
         u3_d   = u2_q;
         l3_d   = l2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            cur_q[c]  <= UNITY;
            tgt_q[c]  <= UNITY;
            step_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
         ramp_en_q <= 1'b0;  clr_q <= 1'b0;  clip_q <= '0;  rb_q <= '0;
         v1_q <= 1'b0; d1_q <= '0;  u1_q <= '0;  l1_q <= 1'b0; g1_q <= '0;
         v2_q <= 1'b0; pi2_q <= '0; pq2_q <= '0; u2_q <= '0;   l2_q <= 1'b0;
         v3_q <= 1'b0; o3_q <= '0;  u3_q <= '0;  l3_q <= 1'b0; sat3_q <= 1'b0;
      end else begin
         cur_q <= cur_d;  tgt_q <= tgt_d;  step_q <= step_d;  cnt_q <= cnt_d;
         ramp_en_q <= ramp_en_d;  clr_q <= clr_d;  clip_q <= clip_d;  rb_q <= rb_d;
         v1_q <= v1_d; d1_q <= d1_d;   u1_q <= u1_d;   l1_q <= l1_d; g1_q <= g1_d;
         v2_q <= v2_d; pi2_q <= pi2_d; pq2_q <= pq2_d; u2_q <= u2_d; l2_q <= l2_d;
         v3_q <= v3_d; o3_q <= o3_d;   u3_q <= u3_d;   l3_q <= l3_d; sat3_q <= sat3_d;
      end
   end

   assign o_tvalid = v3_q;
   assign o_tdata  = o3_q;
   assign o_tuser  = u3_q;
   assign o_tlast  = l3_q;
   assign rb_data  = rb_q;
endmodule
